// File: rtl/ibex_rf_wb_sink_pkg.sv
// ibex_rf_wb_sink_pkg: shared types and constants for the writeback register-file sink.
// Package ibex_pkg, no ports. Provides the scoreboard state type and the hardwired-zero register address.
package ibex_pkg;

    typedef enum logic {
        RF_SB_IDLE = 1'b0,
        RF_SB_PEND = 1'b1
    } rf_sb_state_e;

    localparam logic [31:0] RF_ZERO_ADDR = '0;

endpackage

// File: rtl/ibex_rf_wb_scoreboard.sv
// ibex_rf_wb_scoreboard: one-deep load scoreboard that flags read hazards on a register awaiting LSU data.
// Ports: clk_i/rst_i clock and sync active-high reset; ld_rsv_valid_i/ld_rsv_addr_i reserve a load
// destination; ld_done_i/ld_err_i release it with error status; raddr_a_i/raddr_b_i read addresses
// compared against the reservation; hazard_a_o/hazard_b_o per-port hazard; ld_pending_o reservation
// active; rsv_overflow_o one-cycle pulse for a dropped reservation; ld_err_o sticky load bus error.
module ibex_rf_wb_scoreboard
    import ibex_pkg::*;
#(
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_rsv_valid_i,
    input  logic [AddrWidth-1:0] ld_rsv_addr_i,
    input  logic                 ld_done_i,
    input  logic                 ld_err_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    input  logic [AddrWidth-1:0] raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 ld_pending_o,
    output logic                 rsv_overflow_o,
    output logic                 ld_err_o
);

    localparam logic [AddrWidth-1:0] ZeroAddr = RF_ZERO_ADDR[AddrWidth-1:0];

    rf_sb_state_e         r_state;
    logic [AddrWidth-1:0] r_pend_addr;
    logic                 r_err;
    logic                 r_ovf;

    logic w_pend;
    logic w_release;
    logic w_reserve;
    logic w_overflow;

    assign w_pend     = (r_state == RF_SB_PEND);
    assign w_release  = w_pend && ld_done_i;
    // A same-cycle release frees the slot before the new reservation takes it.
    assign w_reserve  = ld_rsv_valid_i && (!w_pend || ld_done_i);
    assign w_overflow = ld_rsv_valid_i && w_pend && !ld_done_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RF_SB_IDLE;
            r_pend_addr <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_ovf <= w_overflow;
            if (w_reserve) begin
                // x0 is never hazarded, so a reservation on it leaves the scoreboard idle.
                r_state     <= (ld_rsv_addr_i != ZeroAddr) ? RF_SB_PEND : RF_SB_IDLE;
                r_pend_addr <= ld_rsv_addr_i;
                r_err       <= 1'b0;
            end else if (w_release) begin
                r_state <= RF_SB_IDLE;
                r_err   <= ld_err_i;
            end
        end
    end

    assign hazard_a_o     = w_pend && (raddr_a_i == r_pend_addr) && (raddr_a_i != ZeroAddr);
    assign hazard_b_o     = w_pend && (raddr_b_i == r_pend_addr) && (raddr_b_i != ZeroAddr);
    assign ld_pending_o   = w_pend;
    assign rsv_overflow_o = r_ovf;
    assign ld_err_o       = r_err;

    a_done_known: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(ld_done_i));
    a_err_known: assert property (@(posedge clk_i) disable iff (rst_i) ld_done_i |-> !$isunknown(ld_err_i));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !rsv_overflow_o)
        else $warning("load reservation dropped while another was pending");

endmodule

// File: rtl/ibex_rf_wb_sink.sv
// ibex_rf_wb_sink: writeback-port register file with two bypassable read ports and a load scoreboard.
// Ports: clk_i/rst_i clock and sync active-high reset; rf_waddr_wb_i/rf_wdata_wb_i/rf_we_wb_i WB write
// port; ld_rsv_valid_i/ld_rsv_addr_i/ld_done_i/ld_err_i load reservation and release; raddr_a_i/raddr_b_i
// read addresses; rdata_a_o/rdata_b_o read data; hazard_a_o/hazard_b_o pending-load hazard per port;
// ld_pending_o reservation active; rsv_overflow_o dropped-reservation pulse; ld_err_o sticky load error.
module ibex_rf_wb_sink
    import ibex_pkg::*;
#(
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          AddrWidth  = 5,
    parameter logic                 WrBypass   = 1'b1,
    parameter logic [DataWidth-1:0] ResetValue = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] rf_waddr_wb_i,
    input  logic [DataWidth-1:0] rf_wdata_wb_i,
    input  logic                 rf_we_wb_i,
    input  logic                 ld_rsv_valid_i,
    input  logic [AddrWidth-1:0] ld_rsv_addr_i,
    input  logic                 ld_done_i,
    input  logic                 ld_err_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic                 hazard_a_o,
    input  logic [AddrWidth-1:0] raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 hazard_b_o,
    output logic                 ld_pending_o,
    output logic                 rsv_overflow_o,
    output logic                 ld_err_o
);

    localparam int unsigned          NumRegs  = 2 ** AddrWidth;
    localparam logic [AddrWidth-1:0] ZeroAddr = RF_ZERO_ADDR[AddrWidth-1:0];

    // Entry 0 exists only to keep indexing simple; reads of x0 are forced to zero below.
    logic [DataWidth-1:0] r_rf [NumRegs];

    logic w_we;
    logic w_byp_a;
    logic w_byp_b;

    assign w_we = rf_we_wb_i && (rf_waddr_wb_i != ZeroAddr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) r_rf[i] <= ResetValue;
        end else if (w_we) begin
            r_rf[rf_waddr_wb_i] <= rf_wdata_wb_i;
        end
    end

    assign w_byp_a = WrBypass && w_we && (rf_waddr_wb_i == raddr_a_i);
    assign w_byp_b = WrBypass && w_we && (rf_waddr_wb_i == raddr_b_i);

    assign rdata_a_o = (raddr_a_i == ZeroAddr) ? '0 : w_byp_a ? rf_wdata_wb_i : r_rf[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == ZeroAddr) ? '0 : w_byp_b ? rf_wdata_wb_i : r_rf[raddr_b_i];

    ibex_rf_wb_scoreboard #(
        .AddrWidth (AddrWidth)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ld_rsv_valid_i (ld_rsv_valid_i),
        .ld_rsv_addr_i  (ld_rsv_addr_i),
        .ld_done_i      (ld_done_i),
        .ld_err_i       (ld_err_i),
        .raddr_a_i      (raddr_a_i),
        .raddr_b_i      (raddr_b_i),
        .hazard_a_o     (hazard_a_o),
        .hazard_b_o     (hazard_b_o),
        .ld_pending_o   (ld_pending_o),
        .rsv_overflow_o (rsv_overflow_o),
        .ld_err_o       (ld_err_o)
    );

    a_we_known: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(rf_we_wb_i));

endmodule

// File: tb/tb_ibex_rf_wb_sink.sv
// tb_ibex_rf_wb_sink: randomized and directed check of ibex_rf_wb_sink against a behavioural model.
module tb_ibex_rf_wb_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        done = 1'b0;
    logic        lerr = 1'b0;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;

    logic [31:0] rda1, rdb1, rda0, rdb0;
    logic        hza1, hzb1, hza0, hzb0;
    logic        pend1, ovf1, err1, pend0, ovf0, err0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_rf [32];
    bit          m_pend = 0;
    logic [4:0]  m_paddr = '0;
    bit          m_err = 0;
    bit          m_ovf = 0;
    bit          m_started = 0;

    always #5 clk = ~clk;

    ibex_rf_wb_sink #(.WrBypass(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .rf_waddr_wb_i(waddr), .rf_wdata_wb_i(wdata), .rf_we_wb_i(we),
        .ld_rsv_valid_i(rsv_valid), .ld_rsv_addr_i(rsv_addr), .ld_done_i(done), .ld_err_i(lerr),
        .raddr_a_i(ra), .rdata_a_o(rda1), .hazard_a_o(hza1),
        .raddr_b_i(rb), .rdata_b_o(rdb1), .hazard_b_o(hzb1),
        .ld_pending_o(pend1), .rsv_overflow_o(ovf1), .ld_err_o(err1)
    );

    ibex_rf_wb_sink #(.WrBypass(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .rf_waddr_wb_i(waddr), .rf_wdata_wb_i(wdata), .rf_we_wb_i(we),
        .ld_rsv_valid_i(rsv_valid), .ld_rsv_addr_i(rsv_addr), .ld_done_i(done), .ld_err_i(lerr),
        .raddr_a_i(ra), .rdata_a_o(rda0), .hazard_a_o(hza0),
        .raddr_b_i(rb), .rdata_b_o(rdb0), .hazard_b_o(hzb0),
        .ld_pending_o(pend0), .rsv_overflow_o(ovf0), .ld_err_o(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference: x0 reads zero; a live write is visible immediately only when bypass is enabled.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && waddr != 0 && waddr == a) return wdata;
        return m_rf[a];
    endfunction

    function automatic bit exp_hz(input logic [4:0] a);
        return m_pend && a == m_paddr && a != 0;
    endfunction

    always @(posedge clk) begin
        bit was_pend;
        was_pend = m_pend;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_pend = 0;
            m_err = 0;
            m_ovf = 0;
            m_started = 1;
        end else begin
            if (we && waddr != 0) m_rf[waddr] = wdata;
            m_ovf = rsv_valid && was_pend && !done;
            if (was_pend && done) begin
                m_pend = 0;
                m_err = lerr;
            end
            if (rsv_valid && (!was_pend || done)) begin
                m_err = 0;
                if (rsv_addr != 0) begin
                    m_pend = 1;
                    m_paddr = rsv_addr;
                end
            end
        end
    end

    task automatic cyc(input bit rs, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input bit rv, input logic [4:0] rva, input bit dn, input bit er,
                       input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst = rs; we = w; waddr = wa; wdata = wd;
        rsv_valid = rv; rsv_addr = rva; done = dn; lerr = er;
        ra = a; rb = b;
        #1;
        if (m_started) begin
            check("rda_byp", rda1, exp_rd(a, 1));
            check("rdb_byp", rdb1, exp_rd(b, 1));
            check("rda_nobyp", rda0, exp_rd(a, 0));
            check("rdb_nobyp", rdb0, exp_rd(b, 0));
            check("hz_a", {31'b0, hza1}, {31'b0, exp_hz(a)});
            check("hz_b", {31'b0, hzb1}, {31'b0, exp_hz(b)});
            check("hz_a_nobyp", {31'b0, hza0}, {31'b0, exp_hz(a)});
            check("pend", {31'b0, pend1}, {31'b0, m_pend});
            check("ovf", {31'b0, ovf1}, {31'b0, m_ovf});
            check("err", {31'b0, err1}, {31'b0, m_err});
            check("pend_nobyp", {31'b0, pend0}, {31'b0, m_pend});
        end
    endtask

    initial begin
        // Reset, then both boundary registers read as zero with no hazard.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 31);
        check("rst_x1", rda1, 32'h0);
        check("rst_x31", rdb1, 32'h0);
        check("rst_pend", {31'b0, pend1}, 32'h0);
        // Same-cycle bypass versus next-cycle visibility.
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
        check("byp_same", rda1, 32'hDEADBEEF);
        check("nobyp_same", rda0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        check("nobyp_next", rda0, 32'hDEADBEEF);
        // x0 is hardwired and never reserved.
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("x0_read", rda1, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_rsv", {31'b0, pend1}, 32'h0);
        // Hazard holds through the done cycle and drops one cycle later.
        cyc(0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        check("hz7", {31'b0, hzb1}, 32'h1);
        cyc(0, 1, 7, 32'h1234, 0, 0, 1, 0, 0, 7);
        check("hz7_done", {31'b0, hzb1}, 32'h1);
        check("byp7_done", rdb1, 32'h1234);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        check("hz7_drop", {31'b0, hzb1}, 32'h0);
        check("rd7", rdb1, 32'h1234);
        // Overflow pulse and release-then-reserve in one cycle.
        cyc(0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 0, 0, 3, 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        check("ovf_pulse", {31'b0, ovf1}, 32'h1);
        check("ovf_keep3", {31'b0, hza1}, 32'h1);
        check("ovf_not4", {31'b0, hzb1}, 32'h0);
        cyc(0, 0, 0, 0, 1, 4, 1, 0, 3, 4);
        check("ovf_clear", {31'b0, ovf1}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        check("swap_a3", {31'b0, hza1}, 32'h0);
        check("swap_b4", {31'b0, hzb1}, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Sticky error, cleared by a new reservation; reset mid-load.
        cyc(0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("err_set", {31'b0, err1}, 32'h1);
        cyc(0, 0, 0, 0, 1, 10, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
        check("err_clr", {31'b0, err1}, 32'h0);
        check("pend10", {31'b0, pend1}, 32'h1);
        cyc(1, 1, 5, 32'h55, 1, 11, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        check("rst_pend2", {31'b0, pend1}, 32'h0);
        check("rst_x5", rda1, 32'h0);
        check("rst_x7", rdb1, 32'h0);
        // Randomized traffic; reservations only when the slot is free or being released.
        for (int n = 0; n < 500; n++) begin
            bit dn, rv;
            logic [4:0] a, b;
            dn = m_pend ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
            rv = (!m_pend || dn) && ($urandom % 4 == 0);
            a = ($urandom % 3 == 0) ? m_paddr : 5'($urandom);
            b = ($urandom % 3 == 0) ? 5'($urandom % 4) : 5'($urandom);
            cyc($urandom % 80 == 0, $urandom % 2 == 0, 5'($urandom), $urandom,
                rv, 5'($urandom % 12), dn, $urandom % 2 == 0, a, b);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
